// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle for the ID/EX pipeline register.
// slave is the stage's view; master is the view of whatever drives decode and consumes execute.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pc_plus4;
    logic [DATA_W-1:0]     in_imm_ext;
    logic [DATA_W-1:0]     in_rs_data;
    logic [DATA_W-1:0]     in_rt_data;
    logic [REG_ADDR_W-1:0] in_rs_addr;
    logic [REG_ADDR_W-1:0] in_rt_addr;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_is_load;
    logic [CTRL_W-1:0]     in_ctrl;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_pc_plus4;
    logic [DATA_W-1:0]     out_imm_ext;
    logic [DATA_W-1:0]     out_rs_data;
    logic [DATA_W-1:0]     out_rt_data;
    logic [REG_ADDR_W-1:0] out_rs_addr;
    logic [REG_ADDR_W-1:0] out_rt_addr;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_is_load;
    logic [CTRL_W-1:0]     out_ctrl;
    logic [DATA_W-1:0]     out_branch_target;
    logic                  hazard_stall;
    logic [15:0]           stall_count;

    modport master (
        output in_valid, in_pc_plus4, in_imm_ext, in_rs_data, in_rt_data,
               in_rs_addr, in_rt_addr, in_rd_addr, in_is_load, in_ctrl, flush,
               out_ready,
        input  in_ready, out_valid, out_pc_plus4, out_imm_ext, out_rs_data,
               out_rt_data, out_rs_addr, out_rt_addr, out_rd_addr, out_is_load,
               out_ctrl, out_branch_target, hazard_stall, stall_count
    );

    modport slave (
        input  in_valid, in_pc_plus4, in_imm_ext, in_rs_data, in_rt_data,
               in_rs_addr, in_rt_addr, in_rd_addr, in_is_load, in_ctrl, flush,
               out_ready,
        output in_ready, out_valid, out_pc_plus4, out_imm_ext, out_rs_data,
               out_rt_data, out_rs_addr, out_rt_addr, out_rd_addr, out_is_load,
               out_ctrl, out_branch_target, hazard_stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS ID/EX pipeline register: two-entry skid buffer, registered branch target,
// single-cycle load-use stall detection and a saturating stall counter.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     imm_ext;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  is_load;
        logic [CTRL_W-1:0]     ctrl;
        logic [DATA_W-1:0]     branch_target;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Word offset is a signed shift; bits shifted past the top are dropped, so the sum wraps.
    function automatic logic [DATA_W-1:0] branch_target(
        input logic [DATA_W-1:0]        pc,
        input logic signed [DATA_W-1:0] imm
    );
        logic signed [DATA_W-1:0] off;
        off = imm <<< 2;
        return pc + $unsigned(off);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    occ_t                  state_q;
    occ_t                  state_d;
    entry_t                in_entry_p0;
    entry_t                skid_p0;
    entry_t                head_p1;
    logic                  vld_p1;
    logic                  in_ready;
    logic                  accept;
    logic                  pop;
    logic                  load_head;
    logic                  load_skid;
    logic                  move_skid;
    logic                  armed_q;
    logic [REG_ADDR_W-1:0] last_ld_rd_q;
    logic                  hazard_stall;
    logic [15:0]           stall_count_q;

    // p0: incoming entry, branch target formed at acceptance
    always_comb begin
        in_entry_p0               = '0;
        in_entry_p0.pc_plus4      = bus.in_pc_plus4;
        in_entry_p0.imm_ext       = bus.in_imm_ext;
        in_entry_p0.rs_data       = bus.in_rs_data;
        in_entry_p0.rt_data       = bus.in_rt_data;
        in_entry_p0.rs_addr       = bus.in_rs_addr;
        in_entry_p0.rt_addr       = bus.in_rt_addr;
        in_entry_p0.rd_addr       = bus.in_rd_addr;
        in_entry_p0.is_load       = bus.in_is_load;
        in_entry_p0.ctrl          = bus.in_ctrl;
        in_entry_p0.branch_target = branch_target(bus.in_pc_plus4, bus.in_imm_ext);
    end

    assign hazard_stall = armed_q && bus.in_valid &&
                          ((bus.in_rs_addr == last_ld_rd_q) || (bus.in_rt_addr == last_ld_rd_q));

    assign vld_p1   = (state_q != EMPTY);
    assign in_ready = !reset && (state_q != FULL) && !hazard_stall && !bus.flush;
    assign accept   = bus.in_valid && in_ready;
    assign pop      = vld_p1 && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !pop)      state_d = FULL;
                    else if (!accept && pop) state_d = EMPTY;
                end
                FULL:  if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Accept-with-pop from ONE refills the head directly; the skid only takes an entry when the head stays.
    always_comb begin
        load_head = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                EMPTY: load_head = accept;
                ONE: begin
                    load_head = accept && pop;
                    load_skid = accept && !pop;
                end
                FULL:  move_skid = pop;
                default: ;
            endcase
        end
    end

    // p1: head and skid storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_p1 <= '0;
            skid_p0 <= '0;
        end else begin
            if (load_head)      head_p1 <= in_entry_p0;
            else if (move_skid) head_p1 <= skid_p0;
            if (load_skid)      skid_p0 <= in_entry_p0;
        end
    end

    // Tracker is armed for exactly the cycle after a load with a real destination is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q       <= 1'b0;
            last_ld_rd_q  <= '0;
            stall_count_q <= '0;
        end else begin
            armed_q <= !bus.flush && accept && bus.in_is_load && (bus.in_rd_addr != '0);
            if (accept && bus.in_is_load && (bus.in_rd_addr != '0)) last_ld_rd_q <= bus.in_rd_addr;
            if (hazard_stall) stall_count_q <= sat_inc16(stall_count_q);
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = vld_p1;
    assign bus.out_pc_plus4      = head_p1.pc_plus4;
    assign bus.out_imm_ext       = head_p1.imm_ext;
    assign bus.out_rs_data       = head_p1.rs_data;
    assign bus.out_rt_data       = head_p1.rt_data;
    assign bus.out_rs_addr       = head_p1.rs_addr;
    assign bus.out_rt_addr       = head_p1.rt_addr;
    assign bus.out_rd_addr       = head_p1.rd_addr;
    assign bus.out_is_load       = head_p1.is_load;
    assign bus.out_ctrl          = head_p1.ctrl;
    assign bus.out_branch_target = head_p1.branch_target;
    assign bus.hazard_stall      = hazard_stall;
    assign bus.stall_count       = stall_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors with hand-computed branch targets,
// FIFO order, load-use stall, flush and asynchronous reset behaviour.
module tb_id_ex_stage;
    logic clk;
    logic reset;

    id_ex_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(8)) bus ();

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        ld;
        logic [7:0]  ctrl;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [13];
    int   exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic ld, input logic [7:0] ctrl, input logic [31:0] tgt);
        vec_t v;
        v.pc = pc; v.imm = imm; v.rsd = rsd; v.rtd = rtd;
        v.rs = rs; v.rt = rt; v.rd = rd; v.ld = ld; v.ctrl = ctrl; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input int v);
        bus.in_pc_plus4 = vecs[v].pc;
        bus.in_imm_ext  = vecs[v].imm;
        bus.in_rs_data  = vecs[v].rsd;
        bus.in_rt_data  = vecs[v].rtd;
        bus.in_rs_addr  = vecs[v].rs;
        bus.in_rt_addr  = vecs[v].rt;
        bus.in_rd_addr  = vecs[v].rd;
        bus.in_is_load  = vecs[v].ld;
        bus.in_ctrl     = vecs[v].ctrl;
        bus.in_valid    = 1'b1;
    endtask

    // Presents vector v until accepted; returns 1 time unit after the accepting edge, in_valid still high.
    task automatic issue(input int v);
        bit done;
        done = 1'b0;
        set_inputs(v);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(v);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: vector %0d not accepted, required within 20 cycles", v);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every head transfer is checked against the oldest outstanding expectation.
    always @(negedge clk) begin
        int v;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %0h, expected no output", bus.out_pc_plus4);
            end else begin
                v = exp_q.pop_front();
                chk("pop_fields",
                    {bus.out_pc_plus4, bus.out_imm_ext, bus.out_rs_data, bus.out_rt_data,
                     bus.out_rs_addr, bus.out_rt_addr, bus.out_rd_addr, bus.out_is_load, bus.out_ctrl},
                    {vecs[v].pc, vecs[v].imm, vecs[v].rsd, vecs[v].rtd,
                     vecs[v].rs, vecs[v].rt, vecs[v].rd, vecs[v].ld, vecs[v].ctrl});
                chk("pop_target", bus.out_branch_target, vecs[v].tgt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'h00400004, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 5'd1,  5'd2,  5'd3,  1'b0, 8'h11, 32'h00400000);
        vecs[1]  = mk(32'hFFFFFFFC, 32'h00000002, 32'h33333333, 32'h44444444, 5'd4,  5'd5,  5'd6,  1'b0, 8'h22, 32'h00000004);
        vecs[2]  = mk(32'h00001000, 32'h00000010, 32'hA0A0A0A0, 32'hA1A1A1A1, 5'd1,  5'd2,  5'd3,  1'b0, 8'hA0, 32'h00001040);
        vecs[3]  = mk(32'h00002000, 32'hFFFFFFF0, 32'hB0B0B0B0, 32'hB1B1B1B1, 5'd4,  5'd5,  5'd7,  1'b0, 8'hB0, 32'h00001FC0);
        vecs[4]  = mk(32'h00003000, 32'h00007FFF, 32'hC0C0C0C0, 32'hC1C1C1C1, 5'd6,  5'd7,  5'd9,  1'b0, 8'hC0, 32'h00022FFC);
        vecs[5]  = mk(32'h00000100, 32'h00000004, 32'h55555555, 32'h66666666, 5'd9,  5'd10, 5'd8,  1'b1, 8'h05, 32'h00000110);
        vecs[6]  = mk(32'h00000104, 32'h00000000, 32'h77777777, 32'h88888888, 5'd8,  5'd11, 5'd12, 1'b0, 8'h06, 32'h00000104);
        vecs[7]  = mk(32'h00000200, 32'h00000001, 32'h99999999, 32'hAAAAAAAA, 5'd9,  5'd10, 5'd0,  1'b1, 8'h07, 32'h00000204);
        vecs[8]  = mk(32'h00000204, 32'h00000002, 32'hBBBBBBBB, 32'hCCCCCCCC, 5'd0,  5'd8,  5'd13, 1'b0, 8'h08, 32'h0000020C);
        vecs[9]  = mk(32'h00000300, 32'h00000003, 32'h0D0D0D0D, 32'h0E0E0E0E, 5'd1,  5'd2,  5'd14, 1'b0, 8'h09, 32'h0000030C);
        vecs[10] = mk(32'h00000304, 32'hFFFFFFFE, 32'h0F0F0F0F, 32'h10101010, 5'd3,  5'd4,  5'd8,  1'b1, 8'h0A, 32'h000002FC);
        vecs[11] = mk(32'h00000308, 32'h00000005, 32'h12121212, 32'h13131313, 5'd20, 5'd21, 5'd15, 1'b0, 8'h0B, 32'h0000031C);
        vecs[12] = mk(32'h0000030C, 32'h80000000, 32'h14141414, 32'h15151515, 5'd8,  5'd22, 5'd16, 1'b0, 8'h0C, 32'h0000030C);

        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc_plus4 = '0; bus.in_imm_ext = '0; bus.in_rs_data = '0; bus.in_rt_data = '0;
        bus.in_rs_addr = '0; bus.in_rt_addr = '0; bus.in_rd_addr = '0;
        bus.in_is_load = 1'b0; bus.in_ctrl = '0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_hazard", bus.hazard_stall, 0);
        chk("rst_stall_count", bus.stall_count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_target", bus.out_branch_target, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Backward target and wrapping target, single-cycle latency
        bus.out_ready = 1'b1;
        issue(0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid", bus.out_valid, 1);
        chk("bt_backward", bus.out_branch_target, 32'h00400000);
        @(posedge clk); #1;
        issue(1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bt_wrap", bus.out_branch_target, 32'h00000004);
        @(posedge clk); #1;

        // Fill to FULL with A,B; C waits; then drain in order
        bus.out_ready = 1'b0;
        issue(2);
        issue(3);
        set_inputs(4);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_head_A", bus.out_pc_plus4, 32'h00001000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_in_ready2", bus.in_ready, 0);
        chk("hold_head_A", {bus.out_valid, bus.out_pc_plus4, bus.out_branch_target}, {1'b1, 32'h00001000, 32'h00001040});
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(4);
        idle(3);

        // Load rd=8 then rs=8: one stall cycle
        issue(5);
        set_inputs(6);
        @(negedge clk);
        chk("ld_use_stall", bus.hazard_stall, 1);
        chk("ld_use_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_use_stall_end", bus.hazard_stall, 0);
        chk("ld_use_accept", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back(6);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_count_1", bus.stall_count, 1);
        @(posedge clk); #1;

        // Load rd=0 never arms
        issue(7);
        set_inputs(8);
        @(negedge clk);
        chk("rd0_no_stall", bus.hazard_stall, 0);
        chk("rd0_in_ready", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back(8);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rd0_stall_count", bus.stall_count, 1);
        idle(2);

        // FULL with an armed load in the skid, then flush with an incoming instruction
        bus.out_ready = 1'b0;
        issue(9);
        issue(10);
        set_inputs(11);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_out_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        exp_q.delete();
        set_inputs(12);
        @(negedge clk);
        chk("post_flush_out_valid", bus.out_valid, 0);
        chk("post_flush_no_stall", bus.hazard_stall, 0);
        chk("post_flush_in_ready", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back(12);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_flush_stall_count", bus.stall_count, 1);
        idle(2);

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        issue(2);
        issue(3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_stall_count", bus.stall_count, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("arst_rel_in_ready", bus.in_ready, 1);
        chk("arst_rel_out_valid", bus.out_valid, 0);
        idle(3);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute in the MIPS pipeline.
- Consumes the 32-bit sign-extended immediate produced in decode, together with operand data, register addresses and control.
- Computes the registered branch target and detects load-use hazards against the entry immediately ahead.
- Two-entry skid buffer with valid/ready on both sides, plus a synchronous flush from branch resolution.

Parameters:
- DATA_W, 32, datapath / immediate width.
- REG_ADDR_W, 5, register-file address width.
- CTRL_W, 8, opaque control bundle width, passed through unchanged.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle; transfer when in_valid && in_ready.
- in_pc_plus4  in  DATA_W  PC+4 of the instruction.
- in_imm_ext  in  DATA_W  sign-extended immediate.
- in_rs_data, in_rt_data  in  DATA_W  operand values.
- in_rs_addr, in_rt_addr, in_rd_addr  in  REG_ADDR_W  source/dest register numbers.
- in_is_load  in  1  instruction is a load.
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes; transfer when out_valid && out_ready.
- out_pc_plus4, out_imm_ext, out_rs_data, out_rt_data  out  DATA_W  head-entry fields.
- out_rs_addr, out_rt_addr, out_rd_addr  out  REG_ADDR_W  head-entry fields.
- out_is_load  out  1  head-entry field.
- out_ctrl  out  CTRL_W  head-entry field.
- out_branch_target  out  DATA_W  pc_plus4 + (imm_ext << 2), head entry.
- hazard_stall  out  1  load-use stall active this cycle.
- stall_count  out  16  saturating count of hazard_stall cycles.

Behaviour:
Reset:
- out_valid=0, all out_* data=0, hazard_stall=0, stall_count=0.
- Skid slot invalid; hazard tracker cleared.
- in_ready=0 while reset is high, 1 on the first cycle after release.

State machine on occupancy:
- EMPTY: accept -> ONE.
- ONE (head valid):
  - accept without pop -> FULL (new entry goes to skid).
  - pop without accept -> EMPTY.
  - accept with pop -> ONE (new entry goes to head).
- FULL: pop -> ONE (skid moves to head the same edge); no accept possible.

Ready and latency:
- in_ready = !FULL && !hazard_stall && !flush. Purely combinational on current state, with no dependency on out_ready.
- Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N when the stage was EMPTY.
- Order is strictly FIFO.

Branch target:
- Computed at acceptance and stored per entry: in_pc_plus4 + {in_imm_ext[DATA_W-3:0], 2'b00}.
- Result is modulo 2^DATA_W; overflow wraps, no flag.
- Negative immediates give backward targets.

Load-use hazard:
- When an entry with in_is_load=1 and in_rd_addr!=0 is accepted, record last_ld_rd and arm the tracker for the next cycle only.
- In that cycle, hazard_stall = armed && in_valid && (in_rs_addr==last_ld_rd || in_rt_addr==last_ld_rd).
- The tracker disarms after that one cycle whether or not a stall occurred, so a stall lasts exactly 1 cycle.
- Accepting a non-load disarms it. rd=0 never arms.

stall_count:
- +1 on each cycle hazard_stall=1.
- Saturates at 16'hFFFF.
- Cleared only by reset.

Flush (synchronous, highest priority):
- At the edge: head and skid invalid, tracker disarmed.
- In the flush cycle: the input is not accepted (in_ready=0) and out_valid is still presented. A pop of the head in the same cycle is legal but is discarded internally.

Simultaneous events:
- Pop and accept on the same edge from ONE keeps occupancy.
- Pop from FULL while in_valid=1: the input is not accepted that cycle, because in_ready was 0.

Stability:
- While out_valid && !out_ready, all out_* hold constant.

Reset mid-operation:
- Immediate asynchronous clear; in-flight entries are lost.

Test Plan:
- Reset asserted mid-stream with FULL occupancy -> out_valid=0 and stall_count=0 immediately; in_ready=1 one cycle after release.
- Accept pc_plus4=0x00400004, imm_ext=0xFFFFFFFF, out_ready=1 -> next cycle out_valid=1, out_branch_target=0x00400000.
- pc_plus4=0xFFFFFFFC, imm_ext=0x00000002 -> out_branch_target=0x00000004 (wrap).
- out_ready=0, issue 3 back-to-back instructions A,B,C -> A at head, B in skid, in_ready=0 while C waits. Raise out_ready -> outputs A,B,C in order with no loss or duplication.
- Load with rd=8, followed by an instruction with rs=8 -> hazard_stall=1 and in_ready=0 for exactly 1 cycle; accepted the next cycle; stall_count=1. Same pair with rd=0 -> no stall.
- FULL stage and flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, the incoming instruction is dropped, and the tracker is disarmed (a following rs match does not stall).
